// File: rtl/game_pkg.sv
// Shared constants for the game's drawing datapath: screen geometry,
// coordinate widths, colour constants and the plotter state encoding.
package game_pkg;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int DIM_W = 5;
    localparam int COL_W = 3;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [COL_W-1:0] BLACK = 3'b000;
    localparam logic [COL_W-1:0] WHITE = 3'b111;
    localparam logic [COL_W-1:0] RED   = 3'b100;
    localparam logic [COL_W-1:0] GREEN = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major column/row counter for the rectangle scan; flags the last pixel
// of a w x h footprint so the plotter knows when to finish.
module rect_scan_counter
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic [DIM_W-1:0] w_i,
    input  logic [DIM_W-1:0] h_i,
    output logic [DIM_W-1:0] cx_o,
    output logic [DIM_W-1:0] cy_o,
    output logic             last_o
);

    logic [DIM_W-1:0] cx_q, cx_d;
    logic [DIM_W-1:0] cy_q, cy_d;
    logic             row_end;

    assign row_end = (cx_q == w_i - 5'd1);
    assign last_o  = row_end && (cy_q == h_i - 5'd1);
    assign cx_o    = cx_q;
    assign cy_o    = cy_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (step_i) begin
            if (row_end) begin
                cx_d = '0;
                cy_d = cy_q + 5'd1;
            end else begin
                cx_d = cx_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/rect_plotter.sv
// Rasterises one rectangle descriptor into single-pixel VGA writes, one per
// cycle, clipping anything that falls outside the visible screen.
module rect_plotter #(
    parameter int         SCREEN_W     = game_pkg::SCREEN_W,
    parameter int         SCREEN_H     = game_pkg::SCREEN_H,
    parameter logic [2:0] ERASE_COLOUR = game_pkg::BLACK
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       erase,
    input  logic [7:0] rectX,
    input  logic [6:0] rectY,
    input  logic [4:0] rectWidth,
    input  logic [4:0] rectHeight,
    input  logic [2:0] rectColour,
    output logic [7:0] plotX,
    output logic [6:0] plotY,
    output logic [2:0] plotColour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    game_pkg::state_e state_q;
    logic [7:0] x0_q;
    logic [6:0] y0_q;
    logic [4:0] w_q, h_q;
    logic [2:0] col_q;

    logic [4:0] cx, cy;
    logic       last_pixel;
    logic       accept;
    logic [8:0] x_sum;
    logic [7:0] y_sum;

    assign accept = (state_q == game_pkg::IDLE) && start;

    rect_scan_counter u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (accept),
        .step_i  (state_q == game_pkg::DRAW),
        .w_i     (w_q),
        .h_i     (h_q),
        .cx_o    (cx),
        .cy_o    (cy),
        .last_o  (last_pixel)
    );

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the descriptor latches are reset too, so plotX/plotY/plotColour read zero out of reset.
        if (!resetn) begin
            state_q <= game_pkg::IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
        end else begin
            case (state_q)
                game_pkg::IDLE: begin
                    if (start) begin
                        x0_q    <= rectX;
                        y0_q    <= rectY;
                        w_q     <= rectWidth;
                        h_q     <= rectHeight;
                        col_q   <= erase ? ERASE_COLOUR : rectColour;
                        state_q <= (rectWidth == 5'd0 || rectHeight == 5'd0)
                                   ? game_pkg::DONE : game_pkg::DRAW;
                    end
                end
                game_pkg::DRAW: if (last_pixel) state_q <= game_pkg::DONE;
                game_pkg::DONE: state_q <= game_pkg::IDLE;
                default:        state_q <= game_pkg::IDLE;
            endcase
        end
    end

    // Widened sums expose overflow past the screen edge for clipping.
    assign x_sum = {1'b0, x0_q} + {4'b0, cx};
    assign y_sum = {1'b0, y0_q} + {3'b0, cy};

    assign plotX      = x_sum[7:0];
    assign plotY      = y_sum[6:0];
    assign plotColour = col_q;
    assign plot       = (state_q == game_pkg::DRAW) && (x_sum < X_LIM) && (y_sum < Y_LIM);
    assign busy       = (state_q == game_pkg::DRAW) || (state_q == game_pkg::DONE);
    assign done       = (state_q == game_pkg::DONE);

endmodule
